// File: rtl/pipe_ctrl_if.sv
// Pipeline/debug bundle between pipe_ctrl and the core plus serial debug unit.
// The controller takes the slave modport; the core/debug side is the master.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
    logic [31:0]      ird;
    logic [31:0]      ire;
    logic [31:0]      ctre;
    logic             jump_taken;
    logic [31:0]      pc_if;
    logic             dbg_cmd_valid;
    logic [1:0]       dbg_cmd;
    logic [CNT_W-1:0] dbg_n;
    logic             bp_en;
    logic [31:0]      bp_addr;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic             step_done;
    logic             bp_hit;
    logic [31:0]      cycle_cnt;

    modport master (
        output ird, ire, ctre, jump_taken, pc_if,
        output dbg_cmd_valid, dbg_cmd, dbg_n, bp_en, bp_addr,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, halted, step_done, bp_hit, cycle_cnt
    );

    modport slave (
        input  ird, ire, ctre, jump_taken, pc_if,
        input  dbg_cmd_valid, dbg_cmd, dbg_n, bp_en, bp_addr,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, halted, step_done, bp_hit, cycle_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: load-use stall, jump flush and debug run/halt/step FSM.
// Define PIPE_CTRL_BP_EN to include the PC breakpoint logic.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;

    localparam logic [1:0] CMD_HALT = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      cycle_cnt;
    logic             step_done;
    logic             bp_hit;

    logic [4:0] rs1, rs2, rd;
    logic       load_use;
    logic       adv;
    logic       bp;
    logic       go;
    logic       halt_cmd;
    logic       resume_cmd;
    logic       unused_bits;

    assign rs1 = bus.ird[19:15];
    assign rs2 = bus.ird[24:20];
    assign rd  = bus.ire[11:7];

    assign load_use   = bus.ctre[7] & bus.ctre[2] & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
    assign adv        = (state == RUN) | (state == STEP);
    assign halt_cmd   = bus.dbg_cmd_valid & (bus.dbg_cmd == CMD_HALT);
    assign resume_cmd = bus.dbg_cmd_valid & ((bus.dbg_cmd == CMD_RUN) | (bus.dbg_cmd == CMD_STEP));

`ifdef PIPE_CTRL_BP_EN
    // skip_bp lets a resume from a breakpoint fetch past bp_addr exactly once.
    logic skip_bp;
    assign bp          = bus.bp_en & (bus.pc_if == bus.bp_addr) & ~skip_bp;
    assign bus.bp_hit  = bp_hit;
    assign unused_bits = ^{bus.ird[31:25], bus.ird[14:0], bus.ire[31:12], bus.ire[6:0],
                           bus.ctre[31:8], bus.ctre[6:3], bus.ctre[1:0]};
`else
    assign bp          = 1'b0;
    assign bus.bp_hit  = 1'b0;
    assign unused_bits = ^{bus.ird[31:25], bus.ird[14:0], bus.ire[31:12], bus.ire[6:0],
                           bus.ctre[31:8], bus.ctre[6:3], bus.ctre[1:0],
                           bus.bp_en, bus.bp_addr, bp_hit};
`endif

    assign go = adv & ~bp;

    // A taken jump wins over load-use: the ID instruction is wrong-path anyway.
    assign bus.exmem_en   = go;
    assign bus.memwb_en   = go;
    assign bus.idex_en    = go;
    assign bus.pc_en      = go & (bus.jump_taken | ~load_use);
    assign bus.ifid_en    = go & (bus.jump_taken | ~load_use);
    assign bus.ifid_flush = go & bus.jump_taken;
    assign bus.idex_flush = go & (bus.jump_taken | load_use);
    assign bus.halted     = (state == HALT);
    assign bus.step_done  = step_done;
    assign bus.cycle_cnt  = cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HALT;
            cnt       <= '0;
            cycle_cnt <= 32'd0;
            step_done <= 1'b0;
            bp_hit    <= 1'b0;
`ifdef PIPE_CTRL_BP_EN
            skip_bp   <= 1'b0;
`endif
        end else begin
            step_done <= 1'b0;
            bp_hit    <= bp & adv;
            if (go)
                cycle_cnt <= cycle_cnt + 32'd1;
`ifdef PIPE_CTRL_BP_EN
            if (go)
                skip_bp <= 1'b0;
            else if ((state == HALT) && resume_cmd)
                skip_bp <= 1'b1;
`endif
            case (state)
                HALT: begin
                    if (bus.dbg_cmd_valid && bus.dbg_cmd == CMD_RUN) begin
                        state <= RUN;
                    end else if (bus.dbg_cmd_valid && bus.dbg_cmd == CMD_STEP) begin
                        state <= STEP;
                        cnt   <= (bus.dbg_n == '0) ? CNT_W'(1) : bus.dbg_n;
                    end
                end
                RUN: begin
                    if (halt_cmd || bp)
                        state <= HALT;
                end
                STEP: begin
                    if (halt_cmd || bp)
                        state <= HALT;
                    // A breakpoint pre-empts completion, so go is already low here.
                    if (go) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state     <= HALT;
                            step_done <= 1'b1;
                        end
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; breakpoint expectations follow
// whether PIPE_CTRL_BP_EN is defined for the build.
module tb_pipe_ctrl;

    localparam int CNT_W = 16;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] LW_X5        = 32'h0000_A283;
    localparam logic [31:0] LW_X0        = 32'h0000_A003;
    localparam logic [31:0] ADD_X6_X5_X1 = 32'h0012_8333;
    localparam logic [31:0] ADD_X6_X0_X1 = 32'h0010_0333;
    localparam logic [31:0] ADD_X5_X5_X1 = 32'h0012_82B3;
    localparam logic [31:0] CTRL_LOAD    = 32'h0000_0084;
    localparam logic [31:0] CTRL_ALU     = 32'h0000_0080;
    localparam logic [31:0] CTRL_NONE    = 32'h0000_0000;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    localparam logic [31:0] EN_IDLE  = 32'b000_0000;
    localparam logic [31:0] EN_RUN   = 32'b111_1100;
    localparam logic [31:0] EN_STALL = 32'b001_1101;
    localparam logic [31:0] EN_JUMP  = 32'b111_1111;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] en_vec;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign en_vec = {25'd0, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                     bus.memwb_en, bus.ifid_flush, bus.idex_flush};

    task automatic stepClock();
        @(posedge clk);
        #1;
        bus.dbg_cmd_valid = 1'b0;
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] i_d, input logic [31:0] i_e,
                                 input logic [31:0] c_e, input logic jt,
                                 input logic [31:0] pc);
        bus.ird        = i_d;
        bus.ire        = i_e;
        bus.ctre       = c_e;
        bus.jump_taken = jt;
        bus.pc_if      = pc;
        #1;
    endtask

    task automatic issueCmd(input logic [1:0] cmd, input logic [CNT_W-1:0] n);
        bus.dbg_cmd_valid = 1'b1;
        bus.dbg_cmd       = cmd;
        bus.dbg_n         = n;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.dbg_cmd_valid = 1'b0;
        bus.dbg_cmd       = 2'b00;
        bus.dbg_n         = '0;
        bus.bp_en         = 1'b0;
        bus.bp_addr       = 32'h40;
        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h0);
        stepClock();
        stepClock();
        rst = 1'b0;
        stepClock();

        checkOutput("reset_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("reset_enables", en_vec, EN_IDLE);
        checkOutput("reset_cycle_cnt", bus.cycle_cnt, 32'd0);
        checkOutput("reset_step_done", {31'd0, bus.step_done}, 32'd0);
        checkOutput("reset_bp_hit", {31'd0, bus.bp_hit}, 32'd0);

        applyStimulus(ADD_X6_X5_X1, LW_X5, CTRL_LOAD, 1'b0, 32'h0);
        checkOutput("halt_no_flush", en_vec, EN_IDLE);

        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h0);
        issueCmd(2'b01, 16'd0);
        checkOutput("run_cmd_cycle_idle", en_vec, EN_IDLE);
        stepClock();
        checkOutput("run_halted", {31'd0, bus.halted}, 32'd0);
        checkOutput("run_enables", en_vec, EN_RUN);
        checkOutput("run_cycle_cnt0", bus.cycle_cnt, 32'd0);
        stepClock();

        applyStimulus(ADD_X6_X5_X1, LW_X5, CTRL_LOAD, 1'b0, 32'h4);
        checkOutput("load_use_stall", en_vec, EN_STALL);
        checkOutput("cycle_cnt1", bus.cycle_cnt, 32'd1);
        stepClock();
        applyStimulus(NOP, ADD_X6_X5_X1, CTRL_ALU, 1'b0, 32'h4);
        checkOutput("after_stall", en_vec, EN_RUN);
        stepClock();
        applyStimulus(ADD_X6_X0_X1, LW_X0, CTRL_LOAD, 1'b0, 32'h8);
        checkOutput("load_rd_x0", en_vec, EN_RUN);
        stepClock();
        applyStimulus(ADD_X6_X5_X1, ADD_X5_X5_X1, CTRL_ALU, 1'b0, 32'hC);
        checkOutput("alu_no_stall", en_vec, EN_RUN);
        stepClock();
        applyStimulus(ADD_X6_X5_X1, LW_X5, CTRL_LOAD, 1'b1, 32'h10);
        checkOutput("jump_over_load_use", en_vec, EN_JUMP);
        stepClock();

        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h20);
        issueCmd(2'b01, 16'd0);
        checkOutput("run_in_run_enables", en_vec, EN_RUN);
        stepClock();
        checkOutput("run_in_run_ignored", {31'd0, bus.halted}, 32'd0);
        checkOutput("cycle_cnt7", bus.cycle_cnt, 32'd7);
        issueCmd(2'b11, 16'd0);
        stepClock();
        checkOutput("reserved_ignored", {31'd0, bus.halted}, 32'd0);
        checkOutput("cycle_cnt8", bus.cycle_cnt, 32'd8);
        issueCmd(2'b00, 16'd0);
        checkOutput("halt_cmd_cycle_runs", en_vec, EN_RUN);
        stepClock();
        checkOutput("halt_takes_effect", {31'd0, bus.halted}, 32'd1);
        checkOutput("halt_enables", en_vec, EN_IDLE);
        checkOutput("cycle_cnt9", bus.cycle_cnt, 32'd9);

        issueCmd(2'b10, 16'd3);
        stepClock();
        for (int i = 0; i < 3; i++) begin
            checkOutput("step3_go", en_vec, EN_RUN);
            checkOutput("step3_no_done", {31'd0, bus.step_done}, 32'd0);
            stepClock();
        end
        checkOutput("step3_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("step3_done", {31'd0, bus.step_done}, 32'd1);
        checkOutput("step3_cycle_cnt", bus.cycle_cnt, 32'd12);
        stepClock();
        checkOutput("step3_done_pulse", {31'd0, bus.step_done}, 32'd0);
        checkOutput("step3_cnt_hold", bus.cycle_cnt, 32'd12);

        issueCmd(2'b10, 16'd0);
        stepClock();
        checkOutput("step0_go", en_vec, EN_RUN);
        stepClock();
        checkOutput("step0_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("step0_done", {31'd0, bus.step_done}, 32'd1);
        checkOutput("step0_cycle_cnt", bus.cycle_cnt, 32'd13);
        stepClock();

        issueCmd(2'b10, 16'd5);
        stepClock();
        issueCmd(2'b00, 16'd0);
        checkOutput("step5_halt_cycle_go", en_vec, EN_RUN);
        stepClock();
        checkOutput("step5_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("step5_no_done", {31'd0, bus.step_done}, 32'd0);
        checkOutput("step5_cycle_cnt", bus.cycle_cnt, 32'd14);
        stepClock();
        checkOutput("step5_still_no_done", {31'd0, bus.step_done}, 32'd0);

        issueCmd(2'b10, 16'd1);
        stepClock();
        issueCmd(2'b00, 16'd0);
        stepClock();
        checkOutput("halt_final_step_done", {31'd0, bus.step_done}, 32'd1);
        checkOutput("halt_final_step_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("halt_final_cycle_cnt", bus.cycle_cnt, 32'd15);
        stepClock();

        bus.bp_en = 1'b1;
        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h38);
        issueCmd(2'b01, 16'd0);
        stepClock();
        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h3C);
        checkOutput("bp_pre_go", en_vec, EN_RUN);
        stepClock();
        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h40);
`ifdef PIPE_CTRL_BP_EN
        checkOutput("bp_stop_enables", en_vec, EN_IDLE);
        stepClock();
        checkOutput("bp_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("bp_hit", {31'd0, bus.bp_hit}, 32'd1);
        checkOutput("bp_cycle_cnt", bus.cycle_cnt, 32'd16);
        stepClock();
        checkOutput("bp_hit_pulse", {31'd0, bus.bp_hit}, 32'd0);
        issueCmd(2'b01, 16'd0);
        stepClock();
        checkOutput("bp_resume_pass", en_vec, EN_RUN);
        stepClock();
`else
        checkOutput("nobp_pass_enables", en_vec, EN_RUN);
        stepClock();
        checkOutput("nobp_not_halted", {31'd0, bus.halted}, 32'd0);
        checkOutput("nobp_no_hit", {31'd0, bus.bp_hit}, 32'd0);
`endif
        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h44);
        stepClock();
        checkOutput("bp_past_running", {31'd0, bus.halted}, 32'd0);
        checkOutput("bp_past_no_hit", {31'd0, bus.bp_hit}, 32'd0);
        checkOutput("bp_past_cycle_cnt", bus.cycle_cnt, 32'd18);

`ifdef PIPE_CTRL_BP_EN
        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h40);
        issueCmd(2'b00, 16'd0);
        stepClock();
        checkOutput("halt_and_bp_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("halt_and_bp_hit", {31'd0, bus.bp_hit}, 32'd1);
        stepClock();
        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h3C);
        issueCmd(2'b10, 16'd2);
        stepClock();
        checkOutput("step_bp_first_go", en_vec, EN_RUN);
        stepClock();
        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h40);
        checkOutput("step_bp_stop", en_vec, EN_IDLE);
        stepClock();
        checkOutput("step_bp_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("step_bp_hit", {31'd0, bus.bp_hit}, 32'd1);
        checkOutput("step_bp_no_done", {31'd0, bus.step_done}, 32'd0);
        checkOutput("step_bp_cycle_cnt", bus.cycle_cnt, 32'd19);
`endif

        bus.bp_en = 1'b0;
        applyStimulus(NOP, NOP, CTRL_NONE, 1'b0, 32'h100);
        issueCmd(2'b01, 16'd0);
        stepClock();
        checkOutput("pre_reset_running", {31'd0, bus.halted}, 32'd0);
        rst = 1'b1;
        stepClock();
        checkOutput("mid_reset_halted", {31'd0, bus.halted}, 32'd1);
        checkOutput("mid_reset_enables", en_vec, EN_IDLE);
        checkOutput("mid_reset_cycle_cnt", bus.cycle_cnt, 32'd0);
        rst = 1'b0;
        applyStimulus(ADD_X6_X5_X1, LW_X5, CTRL_LOAD, 1'b1, 32'h104);
        stepClock();
        checkOutput("post_reset_idle", en_vec, EN_IDLE);
        checkOutput("post_reset_cycle_cnt", bus.cycle_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32 core under serial-debug control. Drives the enable and flush of the PC and every pipeline register. Combines three sources:
- load-use stall detection,
- branch/jump flush,
- a debug run/halt/step state machine commanded by the serial debug unit.

It sits beside the operand-forwarding logic. Forwarding covers EX/MEM and MEM/WB producers, and this block covers the remaining load-use case.

## Interface
Parameters:
- CNT_W, 16, width of step count.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- ird  in  32  instruction in ID. rs1 = ird[19:15], rs2 = ird[24:20].
- ire  in  32  instruction in EX. rd = ire[11:7].
- ctre  in  32  EX control word. [7] = reg write, [2] = mem-to-reg (load).
- jump_taken  in  1  EX resolved taken branch/jump.
- pc_if  in  32  current fetch PC.
- dbg_cmd_valid  in  1  command strobe, one cycle.
- dbg_cmd  in  2  00 halt, 01 run, 10 step, 11 reserved (ignored).
- dbg_n  in  CNT_W  step cycle count.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush  out  1 each  synchronous clear to NOP.
- halted  out  1  state is HALT.
- step_done  out  1  one-cycle pulse when a step completes.
- bp_hit  out  1  one-cycle pulse on breakpoint halt.
- cycle_cnt  out  32  count of advancing cycles.

## Operation
- States: HALT, RUN, STEP. Reset to HALT.
- Reset values: cnt = 0, skip_bp = 0, cycle_cnt = 0, step_done = 0, bp_hit = 0.
- adv = (state==RUN) | (state==STEP).
- load_use = ctre[7] & ctre[2] & (rd != 0) & (rd==rs1 | rd==rs2).
- bp = bp_en & (pc_if==bp_addr) & ~skip_bp.
- go = adv & ~bp. This is the cycle-advance qualifier.
- Outputs:
  - exmem_en = memwb_en = go.
  - idex_en = go.
  - pc_en = ifid_en = go & (jump_taken | ~load_use).
  - ifid_flush = go & jump_taken.
  - idex_flush = go & (jump_taken | load_use).
  - A taken jump overrides a load-use stall, because the ID instruction is wrong-path.
- Commands are accepted on a cycle with dbg_cmd_valid:
  - halt: accepted in any state; next state HALT.
  - run: accepted only in HALT; next RUN; skip_bp <= 1.
  - step: accepted only in HALT; next STEP; cnt <= (dbg_n==0 ? 1 : dbg_n); skip_bp <= 1.
  - run or step outside HALT is ignored.
- skip_bp clears after the first go cycle. A resume from a breakpoint therefore passes bp_addr once.
- STEP: each go cycle decrements cnt. When a go cycle occurs with cnt==1:
  - next state HALT,
  - step_done pulses on the following cycle.
- Breakpoint: in RUN or STEP, when bp is true:
  - go = 0, so nothing advances; the instruction at bp_addr stays in IF,
  - next state HALT,
  - bp_hit pulses on the following cycle.
  - In STEP, a breakpoint takes precedence over count completion; step_done does not pulse.
- Simultaneous halt command and breakpoint: HALT, and bp_hit still pulses.
- Simultaneous halt command and final step: HALT, step_done pulses.
- cycle_cnt increments on each go cycle and wraps at 2^32.
- rst mid-operation returns to HALT with all registers at their reset values. Enables are 0 the cycle after reset asserts.

## Timing
- All outputs except the pulses and cycle_cnt are combinational from the registered state and the current inputs. Zero-cycle decision.
- Command on cycle t: the first advancing cycle is t+1, and halt takes effect at t+1.
- step N: exactly N go cycles, then halted=1 on the cycle after the last go. step_done is high on that same cycle.
- Load-use produces exactly one bubble: on the stall cycle the ID/EX register receives a NOP and PC/IF/ID hold. On the next cycle the load is in MEM and forwarding supplies the value.

## Configuration
- PIPE_CTRL_BP_EN defined: breakpoint logic as described.
- Not defined:
  - bp is tied 0, bp_hit is tied 0,
  - bp_en and bp_addr are unused,
  - skip_bp is removed.

## Test plan
- Reset, then run; feed `lw x5` in EX with `add x6,x5,x1` in ID -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; normal on the next cycle.
- Same case but the load has rd=x0 -> no stall. Load-use and jump_taken in the same cycle -> pc_en=1, ifid_flush=1, idex_flush=1.
- step with dbg_n=3 -> exactly 3 go cycles, cycle_cnt=3, step_done single pulse, halted=1. dbg_n=0 -> 1 go cycle.
- Breakpoint: bp_en=1, bp_addr=0x40, run until pc_if=0x40 -> go=0 that cycle, bp_hit pulse, HALT. Issue run -> PC advances past 0x40 without re-hit.
- Halt command during STEP with cnt=5 -> HALT next cycle, no step_done. Run command while in RUN is ignored.
- rst asserted mid-RUN -> HALT, cycle_cnt=0, all enables 0. Repeat the breakpoint test with PIPE_CTRL_BP_EN undefined -> no halt at 0x40.
